fetch_ctrl: RTL
===============

# fetch_ctrl

Fetch-stage sequencer that drives the PC-update controls (`Stall`, `PCSel`, `NPCOut`) of the pipelined MIPS fetch stage. It also drives a D-stage flush.

- Holds fetch for a programmable number of cycles after reset.
- Arbitrates between hazard stalls, branch/jump redirects, exceptions and `eret`.
- Latches a branch target that resolves while the pipeline is frozen, and applies it when the freeze releases.
- Sits between the hazard unit / D-stage branch logic and the fetch stage.

## Interface

Parameters:
- `RESET_HOLD`, default 2: cycles fetch stays frozen after reset deasserts (0..15).
- `EXC_VECTOR`, default 32'h0000_4180: exception handler entry PC.

Ports:
- `CLK`: in, 1. Single clock, rising edge.
- `Reset`: in, 1. Synchronous, active-high.
- `StallReq`: in, 1. Hazard unit requests F/D freeze.
- `RedirReq`: in, 1. Taken branch/jump resolved in D this cycle.
- `RedirTarget`: in, 32. Target for `RedirReq`.
- `ExcReq`: in, 1. Exception taken; redirect to `EXC_VECTOR`.
- `EretReq`: in, 1. `eret` in D; redirect to `EPC`.
- `EPC`: in, 32. Return address for `eret`.
- `Stall`: out, 1. To fetch stage: 1 = PC holds.
- `PCSel`: out, 1. To fetch PC mux: 1 = load `NPCOut`, 0 = PC+4.
- `NPCOut`: out, 32. Redirect PC value.
- `FlushD`: out, 1. Clear the F/D pipeline register.
- `Pending`: out, 1. A latched redirect is waiting.
- `RedirCount`: out, 16. Wrapping count of applied redirects (all sources).

## Operation

- **States:** `HOLD`, `RUN`, `PEND`. Registers: `state`, 4-bit `holdcnt`, 32-bit `pend_tgt`, 16-bit `RedirCount`.
- **Outputs:** all outputs except `RedirCount` are combinational from state, registers and inputs.
- **Input priority in `RUN`:** Exc > Eret > Redir > Stall.

**HOLD**
- Outputs: `Stall`=1, `PCSel`=0, `NPCOut`=0, `FlushD`=0.
- All requests are ignored.
- `holdcnt` increments each cycle; the state moves to `RUN` on the cycle `holdcnt`==`RESET_HOLD`-1.
- If `RESET_HOLD`=0, reset enters `RUN` directly.

**RUN**
- `ExcReq`: `PCSel`=1, `NPCOut`=`EXC_VECTOR`, `Stall`=0, `FlushD`=1, even if `StallReq`=1.
- `EretReq` (and no `ExcReq`): same as `ExcReq` but `NPCOut`=`EPC`.
- `RedirReq` & ~`StallReq`: `PCSel`=1, `NPCOut`=`RedirTarget`, `Stall`=0, `FlushD`=0. Branches have a delay slot, so no flush.
- `RedirReq` & `StallReq`: `Stall`=1, `PCSel`=0, `pend_tgt` <= `RedirTarget`, next state `PEND`.
- `StallReq` only: `Stall`=1, `PCSel`=0.
- None of the above: `Stall`=0, `PCSel`=0, `NPCOut`=0.

**PEND**
- Outputs: `PCSel`=1, `NPCOut`=`pend_tgt`, `Stall`=`StallReq`, `Pending`=1.
- On the first cycle with ~`StallReq`, the PC loads `pend_tgt` and the next state is `RUN`.
- `RedirReq` re-asserting in `PEND` is ignored; the stalled branch is still in D, and `pend_tgt` is not overwritten.
- `ExcReq`/`EretReq` in `PEND` override: act as in `RUN`, discard `pend_tgt`, next state `RUN`.

**RedirCount**
- Increments on every cycle where `PCSel`=1 and `Stall`=0 (an actual PC load).
- Wraps from 16'hFFFF to 0.

## Timing

- **Reset:** at the first rising edge with `Reset`=1, the block enters `HOLD`. `holdcnt`=0, `pend_tgt`=0, `RedirCount`=0.
- **Outputs under reset:** from then on, `Stall`=1, `PCSel`=0, `NPCOut`=0, `FlushD`=0, `Pending`=0.
- **Reset mid-operation:** any state, including `PEND`, returns to `HOLD`, and the pending target is lost.
- **Leaving `HOLD`:** the first non-stalled fetch occurs `RESET_HOLD` cycles after `Reset` falls.
- **Redirect latency:** zero cycles. Control is combinational, so a `RUN` redirect makes the PC equal the target at the very next edge.
- **Latched redirect:** the PC equals `pend_tgt` at the edge ending the first ~`StallReq` cycle in `PEND`.
- **Flush:** `FlushD` is a single-cycle pulse per `Exc`/`Eret` request cycle. Requesters hold `ExcReq`/`EretReq` for exactly one cycle.
- **Simultaneous `ExcReq` and `EretReq`:** `ExcReq` wins.
- **Simultaneous `StallReq` and `ExcReq`:** the exception redirect proceeds and the stall is overridden.

## Test plan

1. **Reset hold.** `Reset` high 1 cycle, then low, `RESET_HOLD`=2, no requests.
   - Required: `Stall`=1 for 2 cycles, then 0, `PCSel`=0, `RedirCount`=0.
2. **Unstalled branch.** In `RUN`, `RedirReq`=1, `RedirTarget`=32'h0000_3040, `StallReq`=0.
   - Required: same cycle `PCSel`=1, `NPCOut`=32'h3040, `Stall`=0, `FlushD`=0. `RedirCount`=1 next cycle.
3. **Branch during stall.** `RedirReq`=1 (target 32'h3100) with `StallReq`=1 for 3 cycles, `RedirReq` held.
   - Required: `Pending`=1, `Stall`=1 throughout, `NPCOut`=32'h3100 constant even if `RedirTarget` changes.
   - Required: on the first ~`StallReq` cycle, `PCSel`=1, `Stall`=0. Back in `RUN` afterwards, `RedirCount` +1 once.
4. **Exception beats stall and pending.** In `PEND` with `pend_tgt`=32'h3100, `ExcReq`=1, `StallReq`=1.
   - Required: `PCSel`=1, `NPCOut`=32'h4180, `Stall`=0, `FlushD`=1. Next state `RUN`, `Pending`=0.
5. **Eret versus exception.** `EretReq`=1, `EPC`=32'h3008.
   - Required: `NPCOut`=32'h3008, `FlushD`=1.
   - Then `EretReq`=1 and `ExcReq`=1 together → `NPCOut`=32'h4180.
6. **Counter wrap and reset mid-`PEND`.**
   - Counter wrap: preload via 65,536 redirects → `RedirCount` goes 16'hFFFF→0.
   - Reset mid-`PEND`: assert `Reset` in `PEND` → `HOLD`, `Pending`=0, `pend_tgt` not applied after the hold ends.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: post-reset hold, redirect arbitration (exception, eret, branch)
// and a deferred branch target that is applied once a hazard freeze releases.
module fetch_ctrl #(
    parameter int          RESET_HOLD = 2,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        StallReq,
    input  logic        RedirReq,
    input  logic [31:0] RedirTarget,
    input  logic        ExcReq,
    input  logic        EretReq,
    input  logic [31:0] EPC,
    output logic        Stall,
    output logic        PCSel,
    output logic [31:0] NPCOut,
    output logic        FlushD,
    output logic        Pending,
    output logic [15:0] RedirCount
);

    typedef enum logic [1:0] {HOLD, RUN, PEND} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

    state_t      state, next_state;
    logic [3:0]  holdcnt;
    logic [31:0] pend_tgt;
    logic        load_pend;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= (RESET_HOLD == 0) ? RUN : HOLD;
            holdcnt    <= 4'd0;
            pend_tgt   <= 32'd0;
            RedirCount <= 16'd0;
        end else begin
            state <= next_state;
            if (state == HOLD)
                holdcnt <= holdcnt + 4'd1;
            if (load_pend)
                pend_tgt <= RedirTarget;
            // Only an actual PC load counts; a held PEND redirect does not.
            if (PCSel && !Stall)
                RedirCount <= RedirCount + 16'd1;
        end
    end

    always_comb begin
        next_state = state;
        Stall      = 1'b0;
        PCSel      = 1'b0;
        NPCOut     = 32'd0;
        FlushD     = 1'b0;
        Pending    = 1'b0;
        load_pend  = 1'b0;
        if (Reset) begin
            // Keeps fetch frozen while reset is held, even when RESET_HOLD=0.
            Stall = 1'b1;
        end else begin
            case (state)
                HOLD: begin
                    Stall = 1'b1;
                    if (holdcnt == HOLD_LAST)
                        next_state = RUN;
                end
                RUN, PEND: begin
                    if (ExcReq || EretReq) begin
                        PCSel      = 1'b1;
                        NPCOut     = ExcReq ? EXC_VECTOR : EPC;
                        FlushD     = 1'b1;
                        next_state = RUN;
                    end else if (state == PEND) begin
                        // The stalled branch is still in D, so a re-asserted RedirReq is ignored.
                        PCSel   = 1'b1;
                        NPCOut  = pend_tgt;
                        Stall   = StallReq;
                        Pending = 1'b1;
                        if (!StallReq)
                            next_state = RUN;
                    end else if (RedirReq && !StallReq) begin
                        PCSel  = 1'b1;
                        NPCOut = RedirTarget;
                    end else if (RedirReq) begin
                        Stall      = 1'b1;
                        load_pend  = 1'b1;
                        next_state = PEND;
                    end else if (StallReq) begin
                        Stall = 1'b1;
                    end
                end
                default: begin
                    Stall      = 1'b1;
                    next_state = HOLD;
                end
            endcase
        end
    end

endmodule
